// File: rtl/xyz_dec_pkg.sv
// Shared types for the crop-and-decimate capture path: FSM states and a pixel
// packing helper for the default 3 x 32-bit colour-space pixel.
package xyz_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } dec_state_t;

  localparam int unsigned PIX_CH = 3;
  localparam int unsigned PIX_DW = 32;

  typedef logic [PIX_CH-1:0][PIX_DW-1:0] pixel_t;

  // Channel 0 lands in the LSBs, matching the pix_in/rd_data bus layout.
  function automatic pixel_t pack_pixel(input logic [PIX_DW-1:0] c0,
                                        input logic [PIX_DW-1:0] c1,
                                        input logic [PIX_DW-1:0] c2);
    pixel_t p;
    p[0] = c0;
    p[1] = c1;
    p[2] = c2;
    return p;
  endfunction

endpackage

// File: rtl/xyz_sample_ram.sv
// Simple 1W/1R sample buffer; read data registered (1 cycle), held when rd_en_i=0.
// Same-cycle read of the address being written returns the old word.
module xyz_sample_ram #(
  parameter int DEPTH = 12,
  parameter int AW    = 4,
  parameter int W     = 24
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_dat_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_dat_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_dat_q;

  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Only the output register is reset; the array contents are don't-care.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/xyz_frame_decimator.sv
// Captures a STEP_X/STEP_Y grid inside a crop window of one armed frame into a buffer;
// no backpressure on the pixel stream, read port returns data one cycle after rd_en.
module xyz_frame_decimator
  import xyz_dec_pkg::*;
#(
  parameter  int CH      = 3,
  parameter  int DW      = 32,
  parameter  int CW      = 16,
  parameter  int X_START = 160,
  parameter  int Y_START = 0,
  parameter  int STEP_X  = 47,
  parameter  int STEP_Y  = 47,
  parameter  int OUT_W   = 21,
  parameter  int OUT_H   = 21,
  localparam int DEPTH   = OUT_W * OUT_H,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             frame_val,
  input  logic             pix_val,
  input  logic [CW-1:0]    X_Cont,
  input  logic [CW-1:0]    Y_Cont,
  input  logic [CH*DW-1:0] pix_in,
  output logic             busy,
  output logic             done,
  output logic             short_frm,
  output logic [AW:0]      wr_count,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [CH*DW-1:0] rd_data,
  output logic             rd_valid
);

  localparam int CKW = $clog2(OUT_W + 1);
  localparam int RW  = $clog2(OUT_H + 1);

  localparam logic [CW:0]    X0       = (CW+1)'(X_START);
  localparam logic [CW:0]    Y0       = (CW+1)'(Y_START);
  localparam logic [CW:0]    SX       = (CW+1)'(STEP_X);
  localparam logic [CW:0]    SY       = (CW+1)'(STEP_Y);
  localparam logic [AW:0]    DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LAST_C   = (AW+1)'(DEPTH - 1);
  localparam logic [CKW-1:0] COL_LAST = CKW'(OUT_W - 1);

  dec_state_t     state_q;
  logic           fv_q;
  logic           busy_q;
  logic           done_q;
  logic           short_q;
  logic [CKW-1:0] col_q;
  logic [RW-1:0]  row_q;
  logic [CW:0]    tgt_x_q;
  logic [CW:0]    tgt_y_q;
  logic [AW:0]    wr_count_q;
  logic           rd_valid_q;
  logic           rd_oob_q;

  logic           fv_rise;
  logic           fv_fall;
  logic           hit;
  logic           row_wrap;
  logic [CKW-1:0] col_d;
  logic [RW-1:0]  row_d;
  logic [CW:0]    tgt_x_d;
  logic [CW:0]    tgt_y_d;
  logic [AW:0]    wr_count_d;
  logic           rd_in_range;
  logic [CH*DW-1:0] ram_rd_dat;

  assign fv_rise = frame_val & ~fv_q;
  assign fv_fall = ~frame_val & fv_q;

  // Targets are CW+1 bits wide so a target stepped past the coordinate range never matches.
  assign hit = (state_q == CAPTURE) & pix_val & frame_val &
               ({1'b0, X_Cont} == tgt_x_q) & ({1'b0, Y_Cont} == tgt_y_q);

  assign row_wrap   = (col_q == COL_LAST);
  assign col_d      = row_wrap ? '0 : col_q + CKW'(1);
  assign row_d      = row_wrap ? row_q + RW'(1) : row_q;
  assign tgt_x_d    = row_wrap ? X0 : tgt_x_q + SX;
  assign tgt_y_d    = row_wrap ? tgt_y_q + SY : tgt_y_q;
  assign wr_count_d = wr_count_q + (AW+1)'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      fv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      wr_count_q <= '0;
    end else begin
      fv_q <= frame_val;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= ARM;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
            wr_count_q <= '0;
          end
        end
        ARM: begin
          // Only a fresh frame start is accepted, never a frame already in flight.
          if (fv_rise) begin
            state_q <= CAPTURE;
            col_q   <= '0;
            row_q   <= '0;
            tgt_x_q <= X0;
            tgt_y_q <= Y0;
          end
        end
        CAPTURE: begin
          if (hit) begin
            wr_count_q <= wr_count_d;
            col_q      <= col_d;
            row_q      <= row_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            if (wr_count_q == LAST_C) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              short_q <= 1'b0;
            end
          end else if (fv_fall) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            short_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          short_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

  // Out-of-range reads leave the RAM register untouched and mask the output to zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_oob_q <= ~rd_in_range;
      end
    end
  end

  xyz_sample_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (CH * DW)
  ) u_ram (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .wr_en_i   (hit),
    .wr_addr_i (wr_count_q[AW-1:0]),
    .wr_dat_i  (pix_in),
    .rd_en_i   (rd_en & rd_in_range),
    .rd_addr_i (rd_addr),
    .rd_dat_o  (ram_rd_dat)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign short_frm = short_q;
  assign wr_count  = wr_count_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_oob_q ? '0 : ram_rd_dat;

endmodule

// File: tb/tb_xyz_frame_decimator.sv
// Scenario bench for xyz_frame_decimator on a 16x8 raster with a 4x3 sample grid.
module tb_xyz_frame_decimator;

  localparam int CH = 3, DW = 8, CW = 16;
  localparam int XS = 2, YS = 1, SX = 3, SY = 2, OW = 4, OH = 3;
  localparam int DEPTH = OW * OH;
  localparam int AW = 4;
  localparam int PW = CH * DW;
  localparam int LAST_X = XS + (OW - 1) * SX;
  localparam int LAST_Y = YS + (OH - 1) * SY;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic          frame_val = 1'b0;
  logic          pix_val = 1'b0;
  logic [CW-1:0] X_Cont = '0;
  logic [CW-1:0] Y_Cont = '0;
  logic [PW-1:0] pix_in = '0;
  logic          busy, done, short_frm, rd_valid;
  logic [AW:0]   wr_count;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [PW-1:0] rd_data;

  int n_checks = 0;
  int n_fail = 0;
  logic [PW-1:0] exp_q[$];

  xyz_frame_decimator #(
    .CH(CH), .DW(DW), .CW(CW), .X_START(XS), .Y_START(YS),
    .STEP_X(SX), .STEP_Y(SY), .OUT_W(OW), .OUT_H(OH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .frame_val(frame_val),
    .pix_val(pix_val), .X_Cont(X_Cont), .Y_Cont(Y_Cont), .pix_in(pix_in),
    .busy(busy), .done(done), .short_frm(short_frm), .wr_count(wr_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] exp_pix(input int a);
    logic [7:0] x, y;
    if (a >= DEPTH) return '0;
    x = 8'(XS + (a % OW) * SX);
    y = 8'(YS + (a / OW) * SY);
    return {y, x, x ^ y};
  endfunction

  function automatic bit is_target(input int x, input int y);
    return (x >= XS) && ((x - XS) % SX == 0) && ((x - XS) / SX < OW) &&
           (y >= YS) && ((y - YS) % SY == 0) && ((y - YS) / SY < OH);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_pixel(input int x, input int y);
    frame_val = 1'b1;
    pix_val   = 1'b1;
    X_Cont    = CW'(x);
    Y_Cont    = CW'(y);
    pix_in    = {8'(y), 8'(x), 8'(x ^ y)};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One 16-wide raster frame; when armed, wr_count is checked against the model every cycle.
  task automatic raster(input int rows, input bit armed, input int stop_at,
                        input int start_at, input bit last_check);
    int cnt = 0;
    bit first = 1'b1;
    bit started = 1'b0;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < 16; x++) begin
        drive_pixel(x, y);
        if (!started && start_at >= 0 && cnt == start_at) begin
          start = 1'b1;
          started = 1'b1;
        end
        if (armed && !first && is_target(x, y) && cnt < DEPTH) cnt++;
        first = 1'b0;
        tick();
        start = 1'b0;
        if (armed) begin
          n_checks++;
          if (wr_count !== (AW+1)'(cnt)) begin
            n_fail++;
            $display("FAIL wr_count@(%0d,%0d): got %0d want %0d", x, y, wr_count, cnt);
          end
        end
        if (last_check && x == LAST_X && y == LAST_Y) begin
          n_checks++;
          if (done !== 1'b1 || short_frm !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_on_last_hit: got done=%0b short=%0b busy=%0b want 1 0 0",
                     done, short_frm, busy);
          end
        end
        if (stop_at >= 0 && cnt == stop_at) return;
      end
    end
    frame_val = 1'b0;
    pix_val   = 1'b0;
    tick();
    tick();
  endtask

  task automatic readback(input int lo, input int hi);
    logic [PW-1:0] e;
    for (int a = lo; a <= hi; a++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      exp_q.push_back(exp_pix(a));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        n_fail++;
        $display("FAIL readback[%0d]: got valid=%0b data=%h want 1 %h", a, rd_valid, rd_data, e);
      end
    end
    rd_en = 1'b0;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL readback_idle: got valid=%0b pending=%0d want 0 0", rd_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || short_frm !== 1'b0 || rd_valid !== 1'b0 ||
        wr_count !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%0b done=%0b short=%0b rv=%0b cnt=%0d data=%h want all 0",
               busy, done, short_frm, rd_valid, wr_count, rd_data);
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_armed: got busy=%0b done=%0b want 1 0", busy, done);
    end
    raster(8, 1'b1, -1, -1, 1'b1);
    n_checks++;
    if (done !== 1'b1 || short_frm !== 1'b0 || wr_count !== (AW+1)'(12)) begin
      n_fail++;
      $display("FAIL full_end: got done=%0b short=%0b cnt=%0d want 1 0 12", done, short_frm, wr_count);
    end
    rd_en = 1'b1;
    rd_addr = AW'(5);
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== {8'd3, 8'd5, 8'd6}) begin
      n_fail++;
      $display("FAIL full_rd5: got valid=%0b data=%h want 1 030506", rd_valid, rd_data);
    end
    readback(0, DEPTH - 1);
  endtask

  task automatic test_read_edges();
    rd_en = 1'b1;
    rd_addr = AW'(11);
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== {8'd5, 8'd11, 8'd14}) begin
      n_fail++;
      $display("FAIL rd_addr11: got valid=%0b data=%h want 1 050b0e", rd_valid, rd_data);
    end
    rd_addr = AW'(12);
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL rd_addr12: got valid=%0b data=%h want 1 0", rd_valid, rd_data);
    end
    rd_en = 1'b0;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL rd_hold_zero: got valid=%0b data=%h want 0 0", rd_valid, rd_data);
    end
    rd_en = 1'b1;
    rd_addr = AW'(5);
    tick();
    rd_en = 1'b0;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== {8'd3, 8'd5, 8'd6}) begin
      n_fail++;
      $display("FAIL rd_hold_data: got valid=%0b data=%h want 0 030506", rd_valid, rd_data);
    end
  endtask

  task automatic test_rearm();
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || wr_count !== '0 || busy !== 1'b1 || short_frm !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm: got done=%0b cnt=%0d busy=%0b short=%0b want 0 0 1 0",
               done, wr_count, busy, short_frm);
    end
  endtask

  task automatic test_truncated();
    raster(4, 1'b1, -1, -1, 1'b0);
    n_checks++;
    if (done !== 1'b1 || short_frm !== 1'b1 || wr_count !== (AW+1)'(8) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL truncated: got done=%0b short=%0b cnt=%0d busy=%0b want 1 1 8 0",
               done, short_frm, wr_count, busy);
    end
  endtask

  task automatic test_arming();
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        drive_pixel(x, y);
        start = (y == 0 && x == 5) ? 1'b1 : 1'b0;
        tick();
        start = 1'b0;
      end
    end
    frame_val = 1'b0;
    pix_val = 1'b0;
    tick();
    tick();
    n_checks++;
    if (wr_count !== '0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_midframe: got cnt=%0d busy=%0b done=%0b want 0 1 0", wr_count, busy, done);
    end
    raster(8, 1'b1, -1, 3, 1'b1);
    n_checks++;
    if (done !== 1'b1 || wr_count !== (AW+1)'(12)) begin
      n_fail++;
      $display("FAIL arm_second_start: got done=%0b cnt=%0d want 1 12", done, wr_count);
    end
    readback(0, DEPTH - 1);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    rd_en = 1'b1;
    rd_addr = AW'(0);
    raster(8, 1'b1, 5, -1, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got rv=%0b busy=%0b want 1 1", rd_valid, busy);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || wr_count !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got busy=%0b done=%0b rv=%0b cnt=%0d want 0 0 0 0",
               busy, done, rd_valid, wr_count);
    end
    rd_en = 1'b0;
    frame_val = 1'b0;
    pix_val = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    pulse_start();
    raster(8, 1'b1, -1, -1, 1'b1);
    n_checks++;
    if (done !== 1'b1 || short_frm !== 1'b0 || wr_count !== (AW+1)'(12)) begin
      n_fail++;
      $display("FAIL rstmid_restart: got done=%0b short=%0b cnt=%0d want 1 0 12",
               done, short_frm, wr_count);
    end
    readback(0, DEPTH - 1);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_read_edges();
    test_rearm();
    test_truncated();
    test_arming();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
